// File: rtl/ps2_rx_core.sv
`default_nettype none
// ==========================================================================
// ps2_rx_core : PS/2 device-to-host receiver (sync, deglitch, deframe, FIFO)
// Optional macro PS2_RX_IRQ_EN adds a registered irq_o.      Revision 1.0
// ==========================================================================
module ps2_rx_core #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FILT_LEN    = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  output logic [7:0]                    dat_o,
  output logic                          dat_valid_o,
  input  logic                          dat_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          par_err_o,
  output logic                          frm_err_o,
  output logic                          ovf_o,
  input  logic                          err_clr_i
`ifdef PS2_RX_IRQ_EN
  ,
  output logic                          irq_o
`endif
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]    FILT_MAX = 4'(FILT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Channel 0 is the PS/2 clock, channel 1 the PS/2 data.
  logic [1:0]      raw;
  logic [1:0]      sync0_q, sync1_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic            samp_q, samp_d;

  assign raw = {ps2_dat_i, ps2_clk_i};

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int c = 0; c < 2; c++) begin
      if (sync1_q[c] == filt_q[c]) begin
        fcnt_d[c] = '0;
      end else if (fcnt_q[c] == FILT_MAX) begin
        filt_d[c] = sync1_q[c];
        fcnt_d[c] = '0;
      end else begin
        fcnt_d[c] = fcnt_q[c] + 4'd1;
      end
    end
    samp_d = filt_q[0] & ~filt_d[0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync0_q <= 2'b11;
      sync1_q <= 2'b11;
      filt_q  <= 2'b11;
      fcnt_q  <= '0;
      samp_q  <= 1'b0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      samp_q  <= samp_d;
    end
  end

  // Deframer; filt_q[1] is the data bit captured alongside each sample pulse.
  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shr_q, shr_d;
  logic        pbit_q, pbit_d;
  logic [15:0] to_q, to_d;
  logic        push, set_par, set_frm;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    pbit_d  = pbit_q;
    to_d    = to_q;
    push    = 1'b0;
    set_par = 1'b0;
    set_frm = 1'b0;
    if (!en_i) begin
      state_d = S_IDLE;
      to_d    = '0;
    end else if (samp_q) begin
      to_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!filt_q[1]) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end
        end
        S_DATA: begin
          shr_d = {filt_q[1], shr_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          pbit_d  = filt_q[1];
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!filt_q[1])          set_frm = 1'b1;
          else if (^{shr_q, pbit_q}) push  = 1'b1;
          else                     set_par = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (to_q == TIMEOUT_CYC) begin
        state_d = S_IDLE;
        set_frm = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + 16'd1;
      end
    end else begin
      to_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      shr_q   <= '0;
      pbit_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      pbit_q  <= pbit_d;
      to_q    <= to_d;
    end
  end

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, pop, wr_en;
  logic          perr_q, ferr_q, ovf_q;

  assign full  = (cnt_q == FULL_CNT);
  assign pop   = dat_valid_o & dat_ready_i;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= shr_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (wr_en & ~pop)      cnt_q <= cnt_q + 1'b1;
      else if (~wr_en & pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      perr_q <= set_par | (perr_q & ~err_clr_i);
      ferr_q <= set_frm | (ferr_q & ~err_clr_i);
      ovf_q  <= (push & full & ~pop) | (ovf_q & ~err_clr_i);
    end
  end

  assign dat_o       = mem_q[rd_q];
  assign dat_valid_o = (cnt_q != '0);
  assign fifo_cnt_o  = cnt_q;
  assign par_err_o   = perr_q;
  assign frm_err_o   = ferr_q;
  assign ovf_o       = ovf_q;

`ifdef PS2_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= dat_valid_o | perr_q | ferr_q | ovf_q;
  end
  assign irq_o = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_core.sv
`default_nettype none
// ==========================================================================
// tb_ps2_rx_core : self-checking bench for ps2_rx_core (queue reference model)
// Revision 1.0
// ==========================================================================
module tb_ps2_rx_core;

  localparam int          DEPTH = 8;
  localparam int          FILT  = 4;
  localparam logic [15:0] TMO   = 16'd300;
  localparam int          H     = 20;  // PS/2 clock low/high phase, clk cycles
  localparam int          Q     = 12;  // data setup before the falling edge

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic       ps2_clk = 1'b1, ps2_dat = 1'b1, rdy = 1'b0, clr = 1'b0;
  logic [7:0] dat;
  logic       val, perr, ferr, ovf;
  logic [3:0] cnt;
`ifdef PS2_RX_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  ps2_rx_core #(.FIFO_DEPTH(DEPTH), .FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .dat_o(dat), .dat_valid_o(val), .dat_ready_i(rdy), .fifo_cnt_o(cnt),
    .par_err_o(perr), .frm_err_o(ferr), .ovf_o(ovf), .err_clr_i(clr)
`ifdef PS2_RX_IRQ_EN
    , .irq_o(irq)
`endif
  );

  int         vecs = 0, errs = 0, lat = 2 + FILT + 1;
  logic [7:0] mq[$];
  logic       m_par = 1'b0, m_frm = 1'b0, m_ovf = 1'b0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    return {~bad_stop, ~(^d) ^ bad_par, d, 1'b0};
  endfunction

  // Reference behaviour of one completed frame.
  task automatic model_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    if (bad_stop)                m_frm = 1'b1;
    else if (bad_par)            m_par = 1'b1;
    else if (mq.size() < DEPTH)  mq.push_back(d);
    else                         m_ovf = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_dat = fr[i]; cyc(Q);
      ps2_clk = 1'b0;  cyc(H);
      ps2_clk = 1'b1;  cyc(Q);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(1); clr = 1'b0;
    m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0;
  endtask

  // mode 0 plain, 1 measure latency, 2 pop at the push edge, 3 clear at the push edge
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int glitch_bit, input int mode);
    logic [10:0] fr;
    int k;
    logic seen;
    fr = mk_frame(d, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) begin
      ps2_dat = fr[i];
      cyc(Q);
      if (i == glitch_bit) begin
        ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(Q);
      end
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        k = 0; seen = 1'b0;
        while (k < H && !seen) begin
          @(posedge clk); #1; k++;
          if (val === 1'b1) seen = 1'b1;
        end
        vecs++;
        if (!seen || k < 2 + FILT + 1 || k > 2 + FILT + 3) begin
          errs++;
          $display("FAIL latency: valid after %0d cycles (seen=%0d), required %0d..%0d", k, seen, 2 + FILT + 1, 2 + FILT + 3);
          lat = 2 + FILT + 1;
        end else lat = k;
        if (k < H) cyc(H - k);
      end else if (i == 10 && mode >= 2) begin
        cyc(lat - 1);
        if (mode == 2) begin
          vecs++;
          if (mq.size() == 0 || dat !== mq[0]) begin
            errs++;
            $display("FAIL coincident_pop_head: dat_o=%02h required %02h", dat, (mq.size() == 0) ? 8'hxx : mq[0]);
          end
          if (mq.size() != 0) void'(mq.pop_front());
          rdy = 1'b1;
        end else begin
          clr = 1'b1;
        end
        cyc(1);
        rdy = 1'b0; clr = 1'b0;
        cyc(H - lat);
      end else begin
        cyc(H);
      end
      ps2_clk = 1'b1;
      cyc(Q);
    end
    ps2_dat = 1'b1;
    if (mode == 3) begin m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0; end
    model_frame(d, bad_par, bad_stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    cyc(3);
    vecs++; if (val !== 1'b0)  begin errs++; $display("FAIL reset_valid: %b required 0", val); end
    vecs++; if (cnt !== 4'd0)  begin errs++; $display("FAIL reset_cnt: %0d required 0", cnt); end
    vecs++; if (dat !== 8'h00) begin errs++; $display("FAIL reset_dat: %02h required 00", dat); end
    vecs++; if ({perr, ferr, ovf} !== 3'b000) begin errs++; $display("FAIL reset_flags: %b required 000", {perr, ferr, ovf}); end
`ifdef PS2_RX_IRQ_EN
    vecs++; if (irq !== 1'b0)  begin errs++; $display("FAIL reset_irq: %b required 0", irq); end
`endif
    rst_n = 1'b1; en = 1'b1;
    cyc(5);
    mq.delete(); m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic test_single();
    send_frame(8'h41, 1'b0, 1'b0, -1, 1);
    vecs++; if (dat !== 8'h41) begin errs++; $display("FAIL single_dat: %02h required 41", dat); end
    vecs++; if (cnt !== 4'd1)  begin errs++; $display("FAIL single_cnt: %0d required 1", cnt); end
    vecs++; if ({perr, ferr, ovf} !== 3'b000) begin errs++; $display("FAIL single_flags: %b required 000", {perr, ferr, ovf}); end
`ifdef PS2_RX_IRQ_EN
    vecs++; if (irq !== 1'b1)  begin errs++; $display("FAIL single_irq: %b required 1", irq); end
`endif
    rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
    vecs++; if (cnt !== 4'd0 || val !== 1'b0) begin errs++; $display("FAIL single_pop: cnt=%0d valid=%b required 0/0", cnt, val); end
  endtask

  task automatic test_parity();
    send_frame(8'h41, 1'b1, 1'b0, -1, 0);
    vecs++; if (cnt !== 4'd0)  begin errs++; $display("FAIL parity_nopush: cnt=%0d required 0", cnt); end
    vecs++; if (perr !== 1'b1) begin errs++; $display("FAIL parity_flag: %b required 1", perr); end
    pulse_clr();
    vecs++; if (perr !== 1'b0) begin errs++; $display("FAIL parity_clear: %b required 0", perr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h41 + 8'(i), 1'b0, 1'b0, -1, 0);
    vecs++; if (cnt !== 4'(DEPTH)) begin errs++; $display("FAIL ovf_cnt: %0d required %0d", cnt, DEPTH); end
    vecs++; if (ovf !== m_ovf)     begin errs++; $display("FAIL ovf_flag: %b required %b", ovf, m_ovf); end
    while (mq.size() > 0) begin
      vecs++; if (val !== 1'b1 || dat !== mq[0]) begin errs++; $display("FAIL ovf_pop: valid=%b dat=%02h required 1/%02h", val, dat, mq[0]); end
      rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
    end
    vecs++; if (cnt !== 4'd0) begin errs++; $display("FAIL ovf_drain: cnt=%0d required 0", cnt); end
    pulse_clr();
  endtask

  task automatic test_timeout();
    send_bits(mk_frame(8'hA7, 1'b0, 1'b0), 0, 4);
    ps2_dat = 1'b1;
    cyc(int'(TMO) + 100);
    m_frm = 1'b1;
    vecs++; if (ferr !== m_frm) begin errs++; $display("FAIL timeout_flag: %b required 1", ferr); end
    vecs++; if (cnt !== 4'd0)   begin errs++; $display("FAIL timeout_nopush: cnt=%0d required 0", cnt); end
    pulse_clr();
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
    vecs++; if (cnt !== 4'd1 || dat !== 8'h1C) begin errs++; $display("FAIL timeout_next: cnt=%0d dat=%02h required 1/1c", cnt, dat); end
    rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
  endtask

  task automatic test_glitch();
    send_frame(8'h5A, 1'b0, 1'b0, 4, 0);
    vecs++; if (cnt !== 4'd1 || dat !== 8'h5A) begin errs++; $display("FAIL glitch_frame: cnt=%0d dat=%02h required 1/5a", cnt, dat); end
    vecs++; if ({perr, ferr} !== 2'b00) begin errs++; $display("FAIL glitch_flags: %b required 00", {perr, ferr}); end
    rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
  endtask

  task automatic test_back_to_back_full();
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b0, -1, 0);
    send_frame(8'hC3, 1'b0, 1'b0, -1, 2);
    vecs++; if (cnt !== 4'(DEPTH)) begin errs++; $display("FAIL full_coincident_cnt: %0d required %0d", cnt, DEPTH); end
    vecs++; if (ovf !== 1'b0)      begin errs++; $display("FAIL full_coincident_ovf: %b required 0", ovf); end
    while (mq.size() > 0) begin
      vecs++; if (dat !== mq[0]) begin errs++; $display("FAIL full_coincident_order: dat=%02h required %02h", dat, mq[0]); end
      rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
    end
  endtask

  task automatic test_set_wins();
    send_frame(8'h22, 1'b0, 1'b1, -1, 0);
    send_frame(8'h22, 1'b1, 1'b0, -1, 3);
    vecs++; if (perr !== m_par || ferr !== m_frm) begin errs++; $display("FAIL set_wins: perr=%b ferr=%b required %b/%b", perr, ferr, m_par, m_frm); end
    pulse_clr();
  endtask

  task automatic test_enable();
    logic [10:0] fr;
    fr = mk_frame(8'h00, 1'b0, 1'b0);
    send_bits(fr, 0, 3);
    en = 1'b0;
    send_bits(fr, 4, 10);
    cyc(int'(TMO) + 20);
    en = 1'b1;
    cyc(4);
    vecs++; if ({cnt, perr, ferr} !== 6'd0) begin errs++; $display("FAIL enable_abort: cnt=%0d perr=%b ferr=%b required 0", cnt, perr, ferr); end
    send_frame(8'h33, 1'b0, 1'b0, -1, 0);
    vecs++; if (cnt !== 4'd1 || dat !== 8'h33) begin errs++; $display("FAIL enable_resync: cnt=%0d dat=%02h required 1/33", cnt, dat); end
    rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h77, 1'b1, 1'b0, -1, 0);
    send_frame(8'h78, 1'b0, 1'b0, -1, 0);
    send_bits(mk_frame(8'h79, 1'b0, 1'b0), 0, 3);
    ps2_dat = 1'b0; #3;
    rst_n = 1'b0; #2;
    vecs++; if ({val, cnt, dat, perr, ferr, ovf} !== 16'd0) begin errs++; $display("FAIL reset_mid: valid=%b cnt=%0d dat=%02h flags=%b required all 0", val, cnt, dat, {perr, ferr, ovf}); end
    ps2_dat = 1'b1;
    cyc(2); rst_n = 1'b1; cyc(2);
    mq.delete(); m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0;
    send_frame(8'h9E, 1'b0, 1'b0, -1, 0);
    vecs++; if (cnt !== 4'd1 || dat !== 8'h9E) begin errs++; $display("FAIL reset_mid_next: cnt=%0d dat=%02h required 1/9e", cnt, dat); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic bp, bs;
    int npop;
    for (int it = 0; it < 14; it++) begin
      d  = 8'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 7) == 0);
      send_frame(d, bp, bs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1, 0);
      vecs++; if (cnt !== 4'(mq.size())) begin errs++; $display("FAIL rand_cnt[%0d]: %0d required %0d", it, cnt, mq.size()); end
      vecs++; if ({perr, ferr, ovf} !== {m_par, m_frm, m_ovf}) begin errs++; $display("FAIL rand_flags[%0d]: %b required %b", it, {perr, ferr, ovf}, {m_par, m_frm, m_ovf}); end
      npop = $urandom_range(0, 1) + ((mq.size() > 5) ? 1 : 0);
      for (int p = 0; p < npop && mq.size() > 0; p++) begin
        vecs++; if (dat !== mq[0]) begin errs++; $display("FAIL rand_pop[%0d]: dat=%02h required %02h", it, dat, mq[0]); end
        rdy = 1'b1; cyc(1); rdy = 1'b0; void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_timeout();
    test_glitch();
    test_back_to_back_full();
    test_set_wins();
    test_enable();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
